// File: rtl/cache_fill_pkg.sv
// Shared FSM state type and default line geometry for the cache miss fill sequencer.
package cache_fill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITEBACK,
    FETCH,
    WRITE,
    DONE
  } fill_state_e;

  localparam int DEF_LINELEN = 256;
  localparam int DEF_BUSW    = 64;
  localparam int BEATS       = DEF_LINELEN / DEF_BUSW;
  localparam int BEATLEN     = $clog2(BEATS);

  function automatic int beat_bits(input int linelen, input int busw);
    return $clog2(linelen / busw);
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Wrapping beat index counter: advances when enabled, last_o marks the final beat.
// Synchronous active-low clear.
module cache_beat_counter
  import cache_fill_pkg::*;
#(
  parameter int W = BEATLEN
) (
  input  logic         clk,
  input  logic         clr_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill sequencer: optional dirty-victim writeback, beat-wise line fetch, single array write.
// Define CACHE_FILL_PERF_EN to add saturating FillCount/WritebackCount outputs.
module cache_fill_ctrl
  import cache_fill_pkg::*;
#(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 7,
  parameter int TAGLEN  = 20,
  parameter int LINELEN = BEATS * DEF_BUSW,
  parameter int BUSW    = DEF_BUSW
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          FlushStage,
  input  logic                                          Miss,
  input  logic [SETLEN-1:0]                             MissSet,
  input  logic [TAGLEN-1:0]                             MissTag,
  input  logic [NUMWAYS-1:0]                            VictimWay,
  input  logic                                          VictimDirty,
  input  logic [TAGLEN-1:0]                             VictimTag,
  input  logic [LINELEN-1:0]                            VictimLine,
  output logic                                          BusReq,
  output logic                                          BusWrite,
  output logic [SETLEN+TAGLEN+$clog2(LINELEN/8)-1:0]    BusAdr,
  output logic [BUSW-1:0]                               BusWData,
  input  logic                                          BusAck,
  input  logic [BUSW-1:0]                               BusRData,
  output logic                                          LineWriteEn,
  output logic [NUMWAYS-1:0]                            LineWay,
  output logic [LINELEN-1:0]                            FillLine,
  output logic                                          SetValid,
  output logic                                          ClearDirty,
  output logic                                          ReplWriteEn,
  output logic                                          Stall,
  output logic                                          Done
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [31:0]                                   FillCount,
  output logic [31:0]                                   WritebackCount
`endif
);

  localparam int NBEATLEN = beat_bits(LINELEN, BUSW);
  localparam int OFFB     = $clog2(BUSW / 8);

  fill_state_e         state_q;
  logic [SETLEN-1:0]   set_q;
  logic [TAGLEN-1:0]   mtag_q, vtag_q;
  logic [NUMWAYS-1:0]  way_q;
  logic                dirty_q;
  logic                gap_q;
  logic [LINELEN-1:0]  line_q, fill_q;
  logic [NBEATLEN-1:0] beat;
  logic                beat_last;
  logic                bus_req;
  logic                beat_done;

  // The gap flag holds FETCH off the bus for one cycle after a writeback.
  assign bus_req   = (state_q == WRITEBACK) || ((state_q == FETCH) && !gap_q);
  assign beat_done = bus_req && BusAck;

  cache_beat_counter #(.W(NBEATLEN)) u_beat_cnt (
    .clk     (clk),
    .clr_n_i (reset),
    .en_i    (beat_done),
    .cnt_o   (beat),
    .last_o  (beat_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      set_q   <= '0;
      mtag_q  <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      gap_q   <= 1'b0;
      line_q  <= '0;
      fill_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Miss && !FlushStage) begin
            set_q   <= MissSet;
            mtag_q  <= MissTag;
            vtag_q  <= VictimTag;
            way_q   <= VictimWay;
            dirty_q <= VictimDirty;
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          line_q  <= VictimLine;
          gap_q   <= 1'b0;
          state_q <= dirty_q ? WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          if (BusAck && beat_last) begin
            gap_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (gap_q) begin
            gap_q <= 1'b0;
          end else if (BusAck) begin
            fill_q[int'(beat)*BUSW +: BUSW] <= BusRData;
            if (beat_last) state_q <= WRITE;
          end
        end
        WRITE:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BusReq      = bus_req;
  assign BusWrite    = (state_q == WRITEBACK);
  assign BusAdr      = {(state_q == WRITEBACK) ? vtag_q : mtag_q, set_q, beat, {OFFB{1'b0}}};
  assign BusWData    = line_q[int'(beat)*BUSW +: BUSW];
  assign LineWriteEn = (state_q == WRITE);
  assign LineWay     = (state_q == WRITE) ? way_q : '0;
  assign FillLine    = fill_q;
  assign SetValid    = (state_q == WRITE);
  assign ClearDirty  = (state_q == WRITE);
  assign ReplWriteEn = (state_q == WRITE);
  assign Done        = (state_q == DONE);
  // Stall must rise in the acceptance cycle itself, before the FSM leaves IDLE.
  assign Stall       = (state_q == IDLE) ? (Miss && !FlushStage) : (state_q != DONE);

`ifdef CACHE_FILL_PERF_EN
  logic [31:0] fill_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if ((state_q == WRITE) && (fill_cnt_q != '1)) fill_cnt_q <= fill_cnt_q + 32'd1;
      if ((state_q == CAPTURE) && dirty_q && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign FillCount      = fill_cnt_q;
  assign WritebackCount = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: table of miss scenarios plus reset/flush sequences.
`timescale 1ns/1ps
module tb_cache_fill_ctrl;

  localparam int NUMWAYS = 4;
  localparam int SETLEN  = 7;
  localparam int TAGLEN  = 20;
  localparam int LINELEN = 256;
  localparam int BUSW    = 64;
  localparam int BEATS   = LINELEN / BUSW;
  localparam int ADRW    = SETLEN + TAGLEN + 5;

  logic               clk = 1'b0;
  logic               reset, FlushStage, Miss;
  logic [SETLEN-1:0]  MissSet;
  logic [TAGLEN-1:0]  MissTag, VictimTag;
  logic [NUMWAYS-1:0] VictimWay, LineWay;
  logic               VictimDirty;
  logic [LINELEN-1:0] VictimLine, FillLine;
  logic               BusReq, BusWrite, BusAck;
  logic [ADRW-1:0]    BusAdr;
  logic [BUSW-1:0]    BusWData, BusRData;
  logic               LineWriteEn, SetValid, ClearDirty, ReplWriteEn, Stall, Done;
`ifdef CACHE_FILL_PERF_EN
  logic [31:0]        FillCount, WritebackCount;
`endif

  always #5 clk = ~clk;

  cache_fill_ctrl #(
    .NUMWAYS(NUMWAYS), .SETLEN(SETLEN), .TAGLEN(TAGLEN), .LINELEN(LINELEN), .BUSW(BUSW)
  ) dut (
    .clk(clk), .reset(reset), .FlushStage(FlushStage), .Miss(Miss),
    .MissSet(MissSet), .MissTag(MissTag), .VictimWay(VictimWay),
    .VictimDirty(VictimDirty), .VictimTag(VictimTag), .VictimLine(VictimLine),
    .BusReq(BusReq), .BusWrite(BusWrite), .BusAdr(BusAdr), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData), .LineWriteEn(LineWriteEn), .LineWay(LineWay),
    .FillLine(FillLine), .SetValid(SetValid), .ClearDirty(ClearDirty),
    .ReplWriteEn(ReplWriteEn), .Stall(Stall), .Done(Done)
`ifdef CACHE_FILL_PERF_EN
    , .FillCount(FillCount), .WritebackCount(WritebackCount)
`endif
  );

  typedef struct {
    logic [SETLEN-1:0]  set;
    logic [TAGLEN-1:0]  tag;
    logic [NUMWAYS-1:0] way;
    logic               dirty;
    logic [TAGLEN-1:0]  vtag;
    logic [31:0]        seed;
    logic [15:0]        stalls;    // 2 bits of ack delay per beat, writeback beats first
    logic               junk_ack;  // drive BusAck with garbage whenever BusReq is low
    logic               flush_mid; // raise FlushStage during the fetch phase
    logic               hold;      // keep Miss high after Done into the next entry
    int                 exp_done;  // cycles from acceptance to Done
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;
  int   fills  = 0;
  int   wbs    = 0;

  task automatic chk(input string name, input logic [LINELEN-1:0] act, input logic [LINELEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BUSW-1:0] rd_beat(input logic [31:0] seed, input int b);
    return {seed ^ 32'h5A5A_0000, 32'hC0DE_0000 + 32'(b)};
  endfunction

  function automatic logic [LINELEN-1:0] vline(input logic [31:0] seed);
    logic [LINELEN-1:0] l;
    for (int b = 0; b < BEATS; b++) l[b*BUSW +: BUSW] = {seed, 32'h0000_0B00 + 32'(b)};
    return l;
  endfunction

  function automatic logic [ADRW-1:0] adr(input logic [TAGLEN-1:0] tag, input logic [SETLEN-1:0] set, input int b);
    return {tag, set, 2'(b), 3'b000};
  endfunction

  task automatic run_miss(input vec_t v);
    int nbeats, n, waitc, cyc, b, lwe_cyc, lwe_n, repl_n, last_wb_cyc, first_fetch_cyc;
    logic wb, done_seen, extra;
    logic [LINELEN-1:0] exp_fill, line_v;
    nbeats = v.dirty ? 2 * BEATS : BEATS;
    line_v = vline(v.seed);
    exp_fill = '0;
    for (int k = 0; k < BEATS; k++) exp_fill[k*BUSW +: BUSW] = rd_beat(v.seed, k);
    @(negedge clk);
    Miss = 1'b1; MissSet = v.set; MissTag = v.tag; VictimWay = v.way;
    VictimDirty = v.dirty; VictimTag = v.vtag; VictimLine = line_v;
    BusAck = v.junk_ack; BusRData = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("stall_on_accept", Stall, 1'b1);
    chk("busreq_on_accept", BusReq, 1'b0);
    n = 0; waitc = 0; cyc = 0; lwe_cyc = -1; lwe_n = 0; repl_n = 0;
    last_wb_cyc = -1; first_fetch_cyc = -1; done_seen = 1'b0; extra = 1'b0;
    while (!done_seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      BusAck = 1'b0; BusRData = '0;
      if (ReplWriteEn) repl_n++;
      if (LineWriteEn) begin
        lwe_n++; lwe_cyc = cyc;
        chk("line_way", LineWay, v.way);
        chk("fill_line", FillLine, exp_fill);
        chk("write_strobes", {SetValid, ClearDirty, ReplWriteEn}, 3'b111);
      end
      if (Done) begin
        done_seen = 1'b1;
        chk("done_cycle", cyc, v.exp_done);
        chk("lwe_cycle", lwe_cyc, v.exp_done - 1);
        chk("stall_at_done", Stall, 1'b0);
        chk("lwe_pulses", lwe_n, 1);
        chk("repl_pulses", repl_n, 1);
        chk("beat_total", n, nbeats);
        chk("no_extra_beats", extra, 1'b0);
        if (v.dirty) chk("wb_fetch_gap", first_fetch_cyc - last_wb_cyc, 2);
        FlushStage = 1'b0;
        if (!v.hold) Miss = 1'b0;
        fills++;
        if (v.dirty) wbs++;
      end else begin
        chk("stall_busy", Stall, 1'b1);
        if (BusReq && n >= nbeats) begin
          extra = 1'b1;
        end else if (BusReq) begin
          b  = n % BEATS;
          wb = v.dirty && (n < BEATS);
          chk("bus_write", BusWrite, wb);
          chk("bus_adr", BusAdr, adr(wb ? v.vtag : v.tag, v.set, b));
          if (wb) chk("bus_wdata", BusWData, line_v[b*BUSW +: BUSW]);
          if (!wb && first_fetch_cyc < 0) first_fetch_cyc = cyc;
          if (!wb && v.flush_mid) FlushStage = 1'b1;
          if (waitc < int'(v.stalls[2*n +: 2])) begin
            waitc++;
          end else begin
            BusAck = 1'b1;
            if (!wb) BusRData = rd_beat(v.seed, b);
            if (wb && b == BEATS - 1) last_wb_cyc = cyc;
            n++;
            waitc = 0;
          end
        end else if (v.junk_ack) begin
          BusAck = 1'b1; BusRData = 64'hDEAD_BEEF_DEAD_BEEF;
        end
      end
    end
    if (!done_seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no Done within %0d cycles, beats seen %0d", cyc, n);
      Miss = 1'b0; FlushStage = 1'b0; BusAck = 1'b0;
    end
  endtask

  initial begin
    int  n;
    logic hit, bad;
    //           set     tag        way      d     vtag       seed          stalls    junk  flsh  hold  done
    vecs[0] = '{7'd5,   20'h00012, 4'b0100, 1'b0, 20'h00000, 32'h1111_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 7};
    vecs[1] = '{7'd9,   20'h00055, 4'b0001, 1'b1, 20'h0003A, 32'h2222_0000, 16'h0000, 1'b0, 1'b0, 1'b0, 12};
    vecs[2] = '{7'h7F,  20'hFFFFF, 4'b1000, 1'b0, 20'h00000, 32'h3333_0000, 16'h00E4, 1'b0, 1'b0, 1'b0, 13};
    vecs[3] = '{7'd64,  20'hABCDE, 4'b0010, 1'b1, 20'h12345, 32'h4444_0000, 16'h1B3C, 1'b1, 1'b0, 1'b0, 24};
    vecs[4] = '{7'd17,  20'h00100, 4'b0100, 1'b0, 20'h00000, 32'h5555_0000, 16'h0000, 1'b0, 1'b1, 1'b1, 7};
    vecs[5] = '{7'd18,  20'h00200, 4'b1000, 1'b1, 20'h00777, 32'h6666_0000, 16'h5555, 1'b1, 1'b0, 1'b0, 20};

    reset = 1'b0; FlushStage = 1'b0; Miss = 1'b0; MissSet = '0; MissTag = '0;
    VictimWay = '0; VictimDirty = 1'b0; VictimTag = '0; VictimLine = '0;
    BusAck = 1'b0; BusRData = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {BusReq, BusWrite, BusAdr, BusWData}, '0);
    chk("rst_line", {LineWriteEn, LineWay, SetValid, ClearDirty, ReplWriteEn}, '0);
    chk("rst_fill", FillLine, '0);
    chk("rst_stall_done", {Stall, Done}, 2'b00);
    reset = 1'b1;

    // A flushed miss must not be accepted.
    @(negedge clk);
    Miss = 1'b1; FlushStage = 1'b1;
    #1 chk("flush_stall", Stall, 1'b0);
    @(negedge clk);
    chk("flush_idle_stall", Stall, 1'b0);
    chk("flush_idle_busreq", BusReq, 1'b0);
    Miss = 1'b0; FlushStage = 1'b0;

    // Reset pulled during fetch beat 2 aborts the fill.
    @(negedge clk);
    Miss = 1'b1; MissSet = 7'd3; MissTag = 20'h00077; VictimWay = 4'b0010;
    VictimDirty = 1'b0; VictimTag = '0; VictimLine = vline(32'h1);
    n = 0; hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      BusAck = 1'b0;
      if (BusReq) begin
        BusAck = 1'b1; BusRData = rd_beat(32'h1, n);
        if (n == 2) begin reset = 1'b0; Miss = 1'b0; hit = 1'b1; end
        else n++;
      end
    end
    chk("reset_mid_reached", hit, 1'b1);
    @(negedge clk);
    BusAck = 1'b0;
    chk("reset_mid_busreq", BusReq, 1'b0);
    chk("reset_mid_stall", Stall, 1'b0);
    chk("reset_mid_lwe", LineWriteEn, 1'b0);
    chk("reset_mid_fill", FillLine, '0);
    reset = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      bad = bad | BusReq | LineWriteEn | Stall | Done;
    end
    chk("quiet_after_reset", bad, 1'b0);
    fills = 0; wbs = 0;

    for (int i = 0; i < 6; i++) begin
      run_miss(vecs[i]);
      if (!vecs[i].hold) begin
        @(negedge clk);
        chk("idle_stall", Stall, 1'b0);
        chk("idle_busreq", BusReq, 1'b0);
      end
    end

`ifdef CACHE_FILL_PERF_EN
    chk("fill_count", FillCount, fills);
    chk("writeback_count", WritebackCount, wbs);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
